// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared sizes, index/data types and the XZR index for regfile_core
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_WIDTH = 64;
    localparam int NUM_REGS   = 32;
    localparam int REG_IDX_W  = 5;

    localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd31;

    typedef logic [REG_IDX_W-1:0]  reg_idx_t;
    typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Purpose  : Busy bit per destination register; raises a RAW stall toward ID
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       RegWrite,
    input  logic [4:0] WriteRegister,
    input  logic [4:0] ReadRegister1,
    input  logic [4:0] ReadRegister2,
    input  logic       issue_valid,
    input  logic       issue_writes,
    input  logic [4:0] issue_rd,
    output logic       stall
);

    logic [NUM_REGS-2:0] busy_q;
    logic [NUM_REGS-2:0] busy_d;
    logic [NUM_REGS-1:0] w_busy_all;
    logic                w_wb_en;
    logic                w_set_en;
    logic                w_eb1;
    logic                w_eb2;

    // XZR occupies the top bit and is never busy.
    assign w_busy_all = {1'b0, busy_q};

    // A register being written back this cycle is ready: the bypass supplies it.
    assign w_eb1 = w_busy_all[ReadRegister1] & ~(RegWrite & (WriteRegister == ReadRegister1));
    assign w_eb2 = w_busy_all[ReadRegister2] & ~(RegWrite & (WriteRegister == ReadRegister2));

    assign stall    = ~reset & issue_valid & (w_eb1 | w_eb2);
    assign w_wb_en  = RegWrite & (WriteRegister != ZERO_REG);
    assign w_set_en = issue_valid & ~stall & issue_writes & (issue_rd != ZERO_REG);

    // Set is applied after clear so the newer producer keeps ownership.
    always_comb begin
        busy_d = busy_q;
        if (w_wb_en) begin
            busy_d[WriteRegister] = 1'b0;
        end
        if (w_set_en) begin
            busy_d[issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_core.sv
`default_nettype none
// ============================================================================
// Module   : regfile_core
// Purpose  : 32 x 64-bit ARMv8 register file with XZR, WB->ID bypass and RAW stall
// Revision : 1.0 - initial release
// ============================================================================
module regfile_core #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4:0]            ReadRegister1,
    input  logic [4:0]            ReadRegister2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2,
    input  logic                  RegWrite,
    input  logic [4:0]            WriteRegister,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  issue_valid,
    input  logic                  issue_writes,
    input  logic [4:0]            issue_rd,
    output logic                  stall
);

    import regfile_pkg::*;

    // Storage covers X0-X30 only; XZR has no flops behind it.
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS-1];

    always_comb begin
        regs_d = regs_q;
        if (RegWrite && (WriteRegister != ZERO_REG)) begin
            regs_d[WriteRegister] = WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        ReadData1 = '0;
        if (!reset && (ReadRegister1 != ZERO_REG)) begin
            if (RegWrite && (WriteRegister == ReadRegister1)) begin
                ReadData1 = WriteData;
            end else begin
                ReadData1 = regs_q[ReadRegister1];
            end
        end
    end

    always_comb begin
        ReadData2 = '0;
        if (!reset && (ReadRegister2 != ZERO_REG)) begin
            if (RegWrite && (WriteRegister == ReadRegister2)) begin
                ReadData2 = WriteData;
            end else begin
                ReadData2 = regs_q[ReadRegister2];
            end
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .issue_valid   (issue_valid),
        .issue_writes  (issue_writes),
        .issue_rd      (issue_rd),
        .stall         (stall)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_core
// Purpose  : Scoreboard bench for regfile_core: directed plan plus random traffic
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister, issue_rd;
    logic [63:0] ReadData1, ReadData2, WriteData;
    logic        RegWrite, issue_valid, issue_writes, stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_core dut (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .issue_valid   (issue_valid),
        .issue_writes  (issue_writes),
        .issue_rd      (issue_rd),
        .stall         (stall)
    );

    typedef struct {
        logic        rst;
        logic        rw;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        iv;
        logic        iw;
        logic [4:0]  ird;
    } stim_t;

    typedef struct {
        string       name;
        logic [63:0] e1;
        logic [63:0] e2;
        logic        es;
        logic [2:0]  mask;   // bit0 ReadData1, bit1 ReadData2, bit2 stall
    } exp_t;

    exp_t exp_q[$];

    // Reference model: architectural values plus the set of registers with an
    // outstanding producer.
    logic [63:0] m_regs [32];
    bit          m_pending [32];
    stim_t       cur;

    function automatic stim_t idle();
        stim_t s;
        s.rst = 1'b0; s.rw = 1'b0; s.wr = 5'd0; s.wd = 64'd0;
        s.r1 = 5'd31; s.r2 = 5'd31; s.iv = 1'b0; s.iw = 1'b0; s.ird = 5'd31;
        return s;
    endfunction

    function automatic logic [63:0] m_read(stim_t s, logic [4:0] r);
        if (s.rst || r == 5'd31) return 64'd0;
        if (s.rw && s.wr == r)   return s.wd;
        return m_regs[r];
    endfunction

    function automatic bit m_waiting(stim_t s, logic [4:0] r);
        if (r == 5'd31) return 1'b0;
        return m_pending[r] && !(s.rw && s.wr == r);
    endfunction

    function automatic logic m_stall(stim_t s);
        if (s.rst) return 1'b0;
        return s.iv && (m_waiting(s, s.r1) || m_waiting(s, s.r2));
    endfunction

    task automatic model_clock(stim_t s);
        bit held;
        held = m_stall(s);
        if (s.rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i]    = 64'd0;
                m_pending[i] = 1'b0;
            end
        end else begin
            if (s.rw && s.wr != 5'd31) begin
                m_regs[s.wr]    = s.wd;
                m_pending[s.wr] = 1'b0;
            end
            if (s.iv && !held && s.iw && s.ird != 5'd31) m_pending[s.ird] = 1'b1;
        end
    endtask

    // One cycle: retire the previous cycle into the model, drive new inputs,
    // and queue the model's prediction plus an optional fixed expectation.
    task automatic step(input stim_t s, input string name, input logic [2:0] mask,
                        input logic [63:0] c1, input logic [63:0] c2, input logic cs);
        exp_t e;
        @(posedge clk);
        model_clock(cur);
        #1;
        cur           = s;
        reset         = s.rst;
        RegWrite      = s.rw;
        WriteRegister = s.wr;
        WriteData     = s.wd;
        ReadRegister1 = s.r1;
        ReadRegister2 = s.r2;
        issue_valid   = s.iv;
        issue_writes  = s.iw;
        issue_rd      = s.ird;
        e.name = "model"; e.e1 = m_read(s, s.r1); e.e2 = m_read(s, s.r2);
        e.es = m_stall(s); e.mask = 3'b111;
        exp_q.push_back(e);
        if (mask != 3'b000) begin
            e.name = name; e.e1 = c1; e.e2 = c2; e.es = cs; e.mask = mask;
            exp_q.push_back(e);
        end
    endtask

    task automatic go(input stim_t s);
        step(s, "", 3'b000, 64'd0, 64'd0, 1'b0);
    endtask

    // Monitor: outputs are combinational, so they are valid mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.mask[0]) begin
                    checks++;
                    if (ReadData1 !== e.e1) begin
                        errors++;
                        $display("FAIL %s ReadData1 got %h want %h @%0t", e.name, ReadData1, e.e1, $time);
                    end
                end
                if (e.mask[1]) begin
                    checks++;
                    if (ReadData2 !== e.e2) begin
                        errors++;
                        $display("FAIL %s ReadData2 got %h want %h @%0t", e.name, ReadData2, e.e2, $time);
                    end
                end
                if (e.mask[2]) begin
                    checks++;
                    if (stall !== e.es) begin
                        errors++;
                        $display("FAIL %s stall got %b want %b @%0t", e.name, stall, e.es, $time);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] rand_idx();
        int k;
        k = $urandom_range(0, 9);
        if (k == 0) return 5'd31;
        if (k == 1) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        stim_t s;
        cur = idle();
        cur.rst = 1'b1;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = 5'd0; WriteData = 64'd0;
        ReadRegister1 = 5'd31; ReadRegister2 = 5'd31;
        issue_valid = 1'b0; issue_writes = 1'b0; issue_rd = 5'd31;

        s = idle(); s.rst = 1'b1; s.r1 = 5'd5; s.r2 = 5'd3; s.iv = 1'b1;
        step(s, "reset_outputs", 3'b111, 64'd0, 64'd0, 1'b0);

        // Reset clears storage and busy bits
        s = idle(); s.rw = 1'b1; s.wr = 5'd5; s.wd = 64'h0000010204080001; go(s);
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.ird = 5'd6; go(s);
        s = idle(); s.rst = 1'b1; go(s);
        s = idle(); s.r1 = 5'd5;
        step(s, "reset_clears_x5", 3'b001, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            s = idle(); s.iv = 1'b1; s.r1 = 5'(i); s.r2 = 5'(31 - i);
            step(s, "post_reset_no_stall", 3'b100, 64'd0, 64'd0, 1'b0);
        end

        // Write/read and XZR
        s = idle(); s.rw = 1'b1; s.wr = 5'd18; s.wd = 64'h1111111111111111; go(s);
        s = idle(); s.r2 = 5'd18;
        step(s, "read_x18", 3'b010, 64'd0, 64'h1111111111111111, 1'b0);
        s = idle(); s.rw = 1'b1; s.wr = 5'd31; s.wd = 64'hFFFF_FFFF_FFFF_FFFF; s.r1 = 5'd31;
        step(s, "xzr_no_bypass", 3'b001, 64'd0, 64'd0, 1'b0);
        s = idle();
        step(s, "xzr_reads_zero", 3'b011, 64'd0, 64'd0, 1'b0);

        // Bypass against a different stored value
        s = idle(); s.rw = 1'b1; s.wr = 5'd20; s.wd = 64'h0000_0000_0000_0AAA; go(s);
        s = idle(); s.r1 = 5'd20;
        step(s, "x20_old", 3'b001, 64'h0000_0000_0000_0AAA, 64'd0, 1'b0);
        s = idle(); s.rw = 1'b1; s.wr = 5'd20; s.wd = 64'hDEAD_BEEF_0000_0014; s.r1 = 5'd20;
        step(s, "bypass_x20", 3'b001, 64'hDEAD_BEEF_0000_0014, 64'd0, 1'b0);
        s = idle(); s.r1 = 5'd20;
        step(s, "x20_stored", 3'b001, 64'hDEAD_BEEF_0000_0014, 64'd0, 1'b0);

        // RAW stall on X9 until its writeback
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.ird = 5'd9;
        step(s, "raw_issue", 3'b100, 64'd0, 64'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            s = idle(); s.iv = 1'b1; s.r2 = 5'd9;
            step(s, "raw_stall", 3'b100, 64'd0, 64'd0, 1'b1);
        end
        s = idle(); s.iv = 1'b1; s.r2 = 5'd9; s.rw = 1'b1; s.wr = 5'd9; s.wd = 64'h0000000000000009;
        step(s, "raw_release", 3'b110, 64'd0, 64'h0000000000000009, 1'b0);
        s = idle(); s.iv = 1'b1; s.r2 = 5'd9;
        step(s, "raw_after", 3'b110, 64'd0, 64'h0000000000000009, 1'b0);

        // Set wins over clear on X7
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.ird = 5'd7; go(s);
        s = idle(); s.rw = 1'b1; s.wr = 5'd7; s.wd = 64'd7; s.iv = 1'b1; s.iw = 1'b1; s.ird = 5'd7;
        step(s, "collide_issue", 3'b100, 64'd0, 64'd0, 1'b0);
        s = idle(); s.iv = 1'b1; s.r1 = 5'd7;
        step(s, "set_wins", 3'b100, 64'd0, 64'd0, 1'b1);
        s = idle(); s.iv = 1'b1; s.r1 = 5'd7; s.rw = 1'b1; s.wr = 5'd7; s.wd = 64'h77;
        step(s, "x7_release", 3'b101, 64'h77, 64'd0, 1'b0);

        // XZR and non-writers never become busy
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.ird = 5'd31; go(s);
        s = idle(); s.iv = 1'b1;
        step(s, "xzr_not_busy", 3'b100, 64'd0, 64'd0, 1'b0);
        s = idle(); s.iv = 1'b1; s.iw = 1'b0; s.ird = 5'd4; go(s);
        s = idle(); s.iv = 1'b1; s.r1 = 5'd4;
        step(s, "nonwriter_not_busy", 3'b100, 64'd0, 64'd0, 1'b0);

        // Reset mid-operation drops busy bits
        s = idle(); s.iv = 1'b1; s.iw = 1'b1; s.ird = 5'd3; go(s);
        s = idle(); s.iv = 1'b1; s.r2 = 5'd3;
        step(s, "busy_before_reset", 3'b100, 64'd0, 64'd0, 1'b1);
        s = idle(); s.rst = 1'b1; go(s);
        s = idle(); s.iv = 1'b1; s.r2 = 5'd3;
        step(s, "busy_after_reset", 3'b100, 64'd0, 64'd0, 1'b0);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            s.rst = ($urandom_range(0, 149) == 0);
            s.rw  = 1'($urandom_range(0, 1));
            s.wr  = rand_idx();
            s.wd  = {$urandom, $urandom};
            s.r1  = rand_idx();
            s.r2  = rand_idx();
            s.iv  = ($urandom_range(0, 3) != 0);
            s.iw  = 1'($urandom_range(0, 1));
            s.ird = rand_idx();
            go(s);
        end

        s = idle(); go(s);
        @(posedge clk);
        #1;
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue has %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
